// File: rtl/inst_sram_responder_pkg.sv
// Shared types and defaults for the instruction SRAM responder.
// The CPU-facing types live in cpu_core_params. The SRAM block reuses them so that
// its port widths always match the fetch stage.

package cpu_core_params;
    typedef logic [31:0] Address;
    typedef logic [31:0] CpuData;
endpackage

package inst_sram_params;
    typedef enum logic {INIT, READY} SramState;

    localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;
    typedef logic [$clog2(DEFAULT_DEPTH_WORDS)-1:0] WordIndex;

    localparam cpu_core_params::Address DEFAULT_BASE_ADDRESS = 32'hbfc00000;
    // The all-zero word is a MIPS NOP, so fetches from unwritten memory are harmless.
    localparam cpu_core_params::CpuData DEFAULT_FILL_WORD = 32'h00000000;
endpackage

// File: rtl/inst_sram_responder_array.sv
// Single-port DEPTH_WORDS x 32 synchronous word array with per-byte write enables.
// On a write, the output register captures the old word (read-first behaviour).
// The output register changes only on cycles where enable is high.

module inst_sram_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned INDEX_W = $clog2(DEPTH_WORDS)
) (
    input  logic               clock,
    input  logic               enable,
    input  logic [3:0]         byte_write,
    input  logic [INDEX_W-1:0] index,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data
);

    logic [31:0] mem [DEPTH_WORDS];

    // Registered read of the old word, with byte-masked write in the same cycle.
    always_ff @(posedge clock) begin
        if (enable) begin
            read_data <= mem[index];
            for (int k = 0; k < 4; k++) begin
                if (byte_write[k]) begin
                    mem[index][8*k +: 8] <= write_data[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/inst_sram_responder.sv
// Instruction SRAM responder: zero-fill sequencer, address window decode, sticky
// access fault and read data that holds while the fetch stage is stalled.
// Optional macro INST_SRAM_ACCESS_COUNT_EN adds the read_count and write_count outputs.
//
// state | meaning
// INIT  | writing FILL_WORD to every word in turn; requests are ignored
// READY | serving fetch requests; stays here until reset

module inst_sram_responder
    import inst_sram_params::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter cpu_core_params::Address BASE_ADDRESS = DEFAULT_BASE_ADDRESS,
    parameter cpu_core_params::CpuData FILL_WORD = DEFAULT_FILL_WORD
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   instruction_enabled,
    input  logic [3:0]             instruction_write_strobe,
    input  cpu_core_params::Address instruction_address,
    input  cpu_core_params::CpuData instruction_write_data,
    output cpu_core_params::CpuData instruction_read_data,
`ifdef INST_SRAM_ACCESS_COUNT_EN
    output logic [31:0]            read_count,
    output logic [31:0]            write_count,
`endif
    output logic                   init_done,
    output logic                   access_fault
);

    localparam int unsigned INDEX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] WINDOW_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(DEPTH_WORDS - 1);

    SramState state, state_next;
    logic [INDEX_W-1:0] fill_index;

    cpu_core_params::Address offset;
    logic in_window;
    logic accepted;
    logic [INDEX_W-1:0] word_index;

    logic               array_enable;
    logic [3:0]         array_byte_write;
    logic [INDEX_W-1:0] array_index;
    logic [31:0]        array_write_data;
    logic [31:0]        array_read_data;

    // The response is forced to zero after reset and after an out-of-window access.
    // The array output register is not reset and also changes during the fill,
    // so it is masked until an in-window access loads it.
    logic read_data_zero;

    assign offset     = instruction_address - BASE_ADDRESS;
    assign in_window  = {1'b0, offset} < WINDOW_BYTES;
    assign word_index = offset[INDEX_W+1:2];
    assign accepted   = instruction_enabled && (state == READY);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= INIT;
        else       state <= state_next;
    end

    // Next-state: leave INIT after the last word has been filled
    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (fill_index == LAST_INDEX) state_next = READY;
            READY:   state_next = READY;
            default: state_next = INIT;
        endcase
    end

    // Output decode: the array port is owned by the filler in INIT and by requests in READY
    always_comb begin
        array_enable     = 1'b0;
        array_byte_write = 4'h0;
        array_index      = word_index;
        array_write_data = instruction_write_data;
        case (state)
            INIT: begin
                array_enable     = 1'b1;
                array_byte_write = 4'hf;
                array_index      = fill_index;
                array_write_data = FILL_WORD;
            end
            READY: begin
                array_enable     = accepted && in_window;
                array_byte_write = (accepted && in_window) ? instruction_write_strobe : 4'h0;
            end
            default: ;
        endcase
    end

    // Fill pointer advances only while filling
    always_ff @(posedge clock or posedge reset) begin
        if (reset)              fill_index <= '0;
        else if (state == INIT) fill_index <= fill_index + 1'b1;
    end

    // init_done trails the move to READY by one cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) init_done <= 1'b0;
        else       init_done <= (state == READY);
    end

    // Sticky fault flag and response zero mask, both updated only by accepted requests
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            access_fault   <= 1'b0;
            read_data_zero <= 1'b1;
        end else if (accepted) begin
            if (in_window) begin
                read_data_zero <= 1'b0;
            end else begin
                read_data_zero <= 1'b1;
                access_fault   <= 1'b1;
            end
        end
    end

    assign instruction_read_data = read_data_zero ? 32'h0 : array_read_data;

`ifdef INST_SRAM_ACCESS_COUNT_EN
    // Accepted in-window access counters; they wrap naturally at 2^32
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_count  <= '0;
            write_count <= '0;
        end else if (accepted && in_window) begin
            if (instruction_write_strobe == 4'h0) read_count  <= read_count + 32'd1;
            else                                  write_count <= write_count + 32'd1;
        end
    end
`endif

    inst_sram_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clock      (clock),
        .enable     (array_enable),
        .byte_write (array_byte_write),
        .index      (array_index),
        .write_data (array_write_data),
        .read_data  (array_read_data)
    );

endmodule

// File: tb/tb_inst_sram_responder.sv
// Directed bench for inst_sram_responder with DEPTH_WORDS=16.
module tb_inst_sram_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        instruction_enabled;
    logic [3:0]  instruction_write_strobe;
    logic [31:0] instruction_address;
    logic [31:0] instruction_write_data;
    logic [31:0] instruction_read_data;
    logic        init_done;
    logic        access_fault;
`ifdef INST_SRAM_ACCESS_COUNT_EN
    logic [31:0] read_count;
    logic [31:0] write_count;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    inst_sram_responder #(
        .DEPTH_WORDS(16),
        .BASE_ADDRESS(32'hbfc00000),
        .FILL_WORD(32'h00000000)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .instruction_enabled      (instruction_enabled),
        .instruction_write_strobe (instruction_write_strobe),
        .instruction_address      (instruction_address),
        .instruction_write_data   (instruction_write_data),
        .instruction_read_data    (instruction_read_data),
`ifdef INST_SRAM_ACCESS_COUNT_EN
        .read_count               (read_count),
        .write_count              (write_count),
`endif
        .init_done                (init_done),
        .access_fault             (access_fault)
    );

    typedef struct {
        logic        en;
        logic [3:0]  strobe;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] strobe, input logic [31:0] addr,
                         input logic [31:0] wdata);
        instruction_enabled      = en;
        instruction_write_strobe = strobe;
        instruction_address      = addr;
        instruction_write_data   = wdata;
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Count edges from reset release until init_done; requests are issued in the early cycles.
    task automatic wait_init(input string name, input bit poke_during_init);
        int n = 0;
        bit seen = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            if (poke_during_init && i <= 10)
                drive(1'b1, (i % 2 == 0) ? 4'hf : 4'h0, 32'hbfc00008, 32'hffffffff);
            else
                drive(1'b0, 4'h0, 32'hbfc00008, 32'h0);
            step();
            if (init_done) begin
                seen = 1;
                n = i;
            end else if (poke_during_init) begin
                check({name, " rdata in INIT"}, instruction_read_data, 32'h0);
            end
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        check({name, " init latency"}, 32'(n), 32'd17);
    endtask

    initial begin
        //               en    strb   addr           wdata          exp_rdata      fault
        vecs[0]  = '{1'b1, 4'hf, 32'hbfc00008, 32'h12345678, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 4'h0, 32'hbfc00008, 32'h0,        32'h12345678, 1'b0};
        vecs[2]  = '{1'b1, 4'h5, 32'hbfc00008, 32'haabbccdd, 32'h12345678, 1'b0};
        vecs[3]  = '{1'b1, 4'h0, 32'hbfc00008, 32'h0,        32'h12bb56dd, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 32'hbfc00008, 32'h0,        32'h12bb56dd, 1'b0};
        vecs[5]  = '{1'b0, 4'hf, 32'hbfc00040, 32'hffffffff, 32'h12bb56dd, 1'b0};
        vecs[6]  = '{1'b0, 4'h0, 32'hbfc0003c, 32'h0,        32'h12bb56dd, 1'b0};
        vecs[7]  = '{1'b0, 4'hf, 32'hbfc00000, 32'h55555555, 32'h12bb56dd, 1'b0};
        vecs[8]  = '{1'b0, 4'h0, 32'hbfc0000c, 32'h0,        32'h12bb56dd, 1'b0};
        vecs[9]  = '{1'b1, 4'h0, 32'hbfc0003c, 32'h0,        32'h00000000, 1'b0};
        vecs[10] = '{1'b1, 4'hf, 32'hbfc0003f, 32'hcafef00d, 32'h00000000, 1'b0};
        vecs[11] = '{1'b1, 4'h0, 32'hbfc0003c, 32'h0,        32'hcafef00d, 1'b0};
        vecs[12] = '{1'b1, 4'ha, 32'hbfc0000c, 32'h11223344, 32'h00000000, 1'b0};
        vecs[13] = '{1'b1, 4'h0, 32'hbfc0000d, 32'h0,        32'h11003300, 1'b0};
        vecs[14] = '{1'b1, 4'h0, 32'hbfc00040, 32'h0,        32'h00000000, 1'b1};
        vecs[15] = '{1'b0, 4'h0, 32'hbfc00008, 32'h0,        32'h00000000, 1'b1};
        vecs[16] = '{1'b1, 4'h0, 32'hbfc00008, 32'h0,        32'h12bb56dd, 1'b1};
        vecs[17] = '{1'b1, 4'hf, 32'hbfc00040, 32'hffffffff, 32'h00000000, 1'b1};
        vecs[18] = '{1'b1, 4'h0, 32'hbfc00000, 32'h0,        32'h00000000, 1'b1};
        vecs[19] = '{1'b1, 4'h0, 32'hbfbffffc, 32'h0,        32'h00000000, 1'b1};
        vecs[20] = '{1'b1, 4'h0, 32'hbfc0003c, 32'h0,        32'hcafef00d, 1'b1};

        reset = 1'b1;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) step();
        check("reset rdata", instruction_read_data, 32'h0);
        check("reset init_done", 32'(init_done), 32'd0);
        check("reset fault", 32'(access_fault), 32'd0);

        reset = 1'b0;
        wait_init("first", 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].en, vecs[i].strobe, vecs[i].addr, vecs[i].wdata);
            step();
            check($sformatf("vec%0d rdata", i), instruction_read_data, vecs[i].exp_rdata);
            check($sformatf("vec%0d fault", i), 32'(access_fault), 32'(vecs[i].exp_fault));
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);

        // Reset partway through the fill.
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (7) step();
        check("mid-init init_done low", 32'(init_done), 32'd0);
        reset = 1'b1;
        #1;
        check("async reset fault", 32'(access_fault), 32'd0);
        check("async reset rdata", instruction_read_data, 32'h0);
        step();
        reset = 1'b0;
        wait_init("restart", 1'b1);

        drive(1'b1, 4'h0, 32'hbfc00008, 32'h0);
        step();
        check("word2 refilled", instruction_read_data, 32'h0);
        check("fault after reinit", 32'(access_fault), 32'd0);

`ifdef INST_SRAM_ACCESS_COUNT_EN
        drive(1'b1, 4'h0, 32'hbfc00000, 32'h0);        step();
        drive(1'b1, 4'hf, 32'hbfc00004, 32'h01020304); step();
        drive(1'b0, 4'h0, 32'hbfc00004, 32'h0);        step();
        drive(1'b1, 4'h0, 32'hbfc00040, 32'h0);        step();
        drive(1'b1, 4'h3, 32'hbfc00010, 32'h0000abcd); step();
        drive(1'b1, 4'h0, 32'hbfc00004, 32'h0);        step();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        check("counted read data", instruction_read_data, 32'h01020304);
        check("read_count", read_count, 32'd3);
        check("write_count", write_count, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/inst_sram_responder.md
Name: inst_sram_responder

Overview:
- Responder end of the core's instruction SRAM interface: accepts enable/strobe/address/write-data from the fetch stage and returns read data one cycle later.
- Contains a byte-writable word array, a post-reset zero-fill sequencer, address window checking and a sticky fault flag.
- Sits in the SoC/testbench wrapper beside the CPU core and replaces a vendor SRAM for simulation and small FPGA builds.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two, at least 2.
- BASE_ADDRESS, 32'hbfc00000, byte address that maps to word 0.
- FILL_WORD, 32'h00000000, value written to every word during init (MIPS NOP).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- instruction_enabled  in  1  request valid this cycle.
- instruction_write_strobe  in  4  per-byte write enable; 4'h0 means read.
- instruction_address  in  32  byte address (cpu_core_params::Address).
- instruction_write_data  in  32  write data (cpu_core_params::CpuData).
- instruction_read_data  out  32  read data, valid the cycle after an accepted read.
- init_done  out  1  high once zero-fill is complete; the core reset is held until this is high.
- access_fault  out  1  sticky; set by any accepted out-of-window access.

Behaviour:
- Reset (async assert, sync release): state=INIT, fill_index=0, instruction_read_data=0, init_done=0, access_fault=0. Array contents are not reset.
- FSM INIT:
  - Each cycle writes FILL_WORD to word fill_index, then increments fill_index.
  - After writing word DEPTH_WORDS-1, go to READY; init_done is high from the next cycle.
  - Requests are ignored in INIT (no write, read_data held, fault unchanged).
- FSM READY is terminal until reset. Reset mid-INIT restarts the fill at index 0.
- Address decode:
  - offset = instruction_address - BASE_ADDRESS, computed mod 2^32.
  - In window if offset < DEPTH_WORDS*4.
  - word index = offset[log2(DEPTH_WORDS)+1:2]; address bits [1:0] are ignored.
- Accepted request: instruction_enabled && state==READY.
- Read (strobe 4'h0, accepted, in window): instruction_read_data <= array[index] at the next clock edge. Latency is exactly 1 cycle.
- Write (strobe nonzero, accepted, in window):
  - Byte k of the array word is updated iff strobe[k].
  - instruction_read_data <= the old word (read-first).
- Out-of-window accepted access:
  - No array change; instruction_read_data <= 32'h0; access_fault <= 1.
  - access_fault clears only on reset.
- No accepted request: instruction_read_data holds its previous value. The fetch stage depends on this while stalled.
- Back-to-back accepted requests are supported every cycle; there is no backpressure.

Optional Feature:
- Macro INST_SRAM_ACCESS_COUNT_EN.
- Defined: adds output ports read_count[31:0] and write_count[31:0].
  - Each increments by 1 on every accepted in-window read or write respectively.
  - Both wrap from 32'hffffffff to 0, reset to 0, and do not count during INIT.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package inst_sram_params:
  - typedef enum logic {INIT, READY} SramState.
  - WordIndex type sized from DEPTH_WORDS.
  - FILL_WORD default and BASE_ADDRESS default constants.
  - Reuses cpu_core_params::Address and cpu_core_params::CpuData.
- Sub-module inst_sram_array:
  - Single-port synchronous array, DEPTH_WORDS x 32.
  - Per-byte write enables, read-first registered output.
  - The top-level module owns the FSM, address decode, fault flag, output hold mux and optional counters.

Test Plan:
- Init: release reset with DEPTH_WORDS=16 -> init_done rises 17 cycles after release (16 fill cycles plus 1); read of 0xbfc0003c then returns 0x00000000.
- Write/read: write 0x12345678 strobe 4'hf at 0xbfc00008, then read 0xbfc00008 -> 0x12345678 one cycle later. Write 0xaabbccdd strobe 4'b0101 to the same address, then read -> 0x12bb56dd.
- Hold: read 0xbfc00008 (returns 0x12bb56dd), then drop instruction_enabled for 5 cycles -> read_data stays 0x12bb56dd; address changes while enable is low have no effect.
- Fault: read 0xbfc00040 (DEPTH_WORDS=16) -> read_data 0, access_fault 1; a subsequent valid read keeps access_fault 1; reset clears it.
- Reset mid-init: assert reset at fill_index 7, release -> init_done stays low and rises 17 cycles after the second release; requests during INIT leave read_data 0 and memory untouched.
- With INST_SRAM_ACCESS_COUNT_EN: 3 reads, 2 writes and 1 out-of-window read -> read_count=3, write_count=2.
